// File: rtl/ddr_app_master.sv
// ddr_app_master: burst initiator for the DDR controller native app interface.
// Splits each request into per-beat commands, streams write beats and returns read beats.
module ddr_app_master #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 256,
  parameter int LEN_WIDTH       = 8,
  parameter int ADDR_STEP       = 8,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_mask,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_last,
  output logic                    busy,
  output logic                    err_unexp_rd,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  input  logic                    app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  input  logic                    app_rd_data_valid,
  input  logic                    init_calib_complete
);

  localparam int CNT_WIDTH = LEN_WIDTH + 1;
  localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OUT_WIDTH-1:0]  OUT_MAX  = OUT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [OUT_WIDTH-1:0]  OUT_ONE  = OUT_WIDTH'(1);
  localparam logic [OUT_WIDTH-1:0]  OUT_ZERO = OUT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = CNT_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [2:0]              cmd_r;
  logic [CNT_WIDTH-1:0]    cmd_left_r;
  logic [CNT_WIDTH-1:0]    data_left_r;
  logic [OUT_WIDTH-1:0]    outstanding_r;
  logic [DATA_WIDTH-1:0]   rd_data_r;
  logic                    rd_valid_r;
  logic                    rd_last_r;
  logic                    err_r;

  logic                    req_ready_s;
  logic                    req_fire_s;
  logic                    app_en_s;
  logic                    cmd_fire_s;
  logic                    wdf_wren_s;
  logic                    wr_ready_s;
  logic                    data_fire_s;
  logic                    rd_inc_s;
  logic                    rd_dec_s;
  logic                    unexp_s;
  logic                    rd_last_s;
  logic [CNT_WIDTH-1:0]    cmd_left_nxt_s;
  logic [CNT_WIDTH-1:0]    data_left_nxt_s;
  logic [OUT_WIDTH-1:0]    outstanding_nxt_s;

  // Handshake qualifiers derived from the registered burst state.
  always_comb begin
    req_ready_s = 1'b0;
    app_en_s    = 1'b0;
    wdf_wren_s  = 1'b0;
    wr_ready_s  = 1'b0;
    if (rst) begin
      req_ready_s = 1'b0;
    end else begin
      req_ready_s = (state_r == IDLE) && init_calib_complete;
    end
    if (state_r == WR_BURST) begin
      app_en_s   = (cmd_left_r != CNT_ZERO);
      wdf_wren_s = (data_left_r != CNT_ZERO) && wr_valid;
      wr_ready_s = (data_left_r != CNT_ZERO) && app_wdf_rdy;
    end else if (state_r == RD_BURST) begin
      // Read commands throttle once the return window is full.
      app_en_s = (cmd_left_r != CNT_ZERO) && (outstanding_r < OUT_MAX);
    end else begin
      app_en_s = 1'b0;
    end
  end

  assign req_fire_s  = req_valid && req_ready_s;
  assign cmd_fire_s  = app_en_s && app_rdy;
  assign data_fire_s = wdf_wren_s && app_wdf_rdy;
  assign rd_inc_s    = cmd_fire_s && (state_r == RD_BURST);
  assign rd_dec_s    = app_rd_data_valid && (outstanding_r != OUT_ZERO);
  assign unexp_s     = app_rd_data_valid && (outstanding_r == OUT_ZERO);

  // Next values of the beat and outstanding-read counters.
  always_comb begin
    cmd_left_nxt_s    = cmd_left_r;
    data_left_nxt_s   = data_left_r;
    outstanding_nxt_s = outstanding_r;
    if (cmd_fire_s) begin
      cmd_left_nxt_s = cmd_left_r - CNT_ONE;
    end else begin
      cmd_left_nxt_s = cmd_left_r;
    end
    if (data_fire_s) begin
      data_left_nxt_s = data_left_r - CNT_ONE;
    end else begin
      data_left_nxt_s = data_left_r;
    end
    case ({rd_inc_s, rd_dec_s})
      2'b10:   outstanding_nxt_s = outstanding_r + OUT_ONE;
      2'b01:   outstanding_nxt_s = outstanding_r - OUT_ONE;
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  assign rd_last_s = rd_dec_s && (outstanding_nxt_s == OUT_ZERO) && (cmd_left_nxt_s == CNT_ZERO);

  // Burst FSM, counters and registered read-return path.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r       <= IDLE;
      addr_r        <= '0;
      cmd_r         <= 3'b000;
      cmd_left_r    <= '0;
      data_left_r   <= '0;
      outstanding_r <= '0;
      rd_data_r     <= '0;
      rd_valid_r    <= 1'b0;
      rd_last_r     <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      rd_data_r     <= app_rd_data;
      rd_valid_r    <= app_rd_data_valid;
      rd_last_r     <= rd_last_s;
      outstanding_r <= outstanding_nxt_s;
      if (unexp_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (req_fire_s) begin
            addr_r      <= req_addr;
            cmd_r       <= req_write ? 3'b000 : 3'b001;
            cmd_left_r  <= {1'b0, req_len} + CNT_ONE;
            data_left_r <= {1'b0, req_len} + CNT_ONE;
            state_r     <= req_write ? WR_BURST : RD_BURST;
          end
        end
        WR_BURST: begin
          if (cmd_fire_s) begin
            addr_r <= addr_r + STEP;
          end
          cmd_left_r  <= cmd_left_nxt_s;
          data_left_r <= data_left_nxt_s;
          if ((cmd_left_nxt_s == CNT_ZERO) && (data_left_nxt_s == CNT_ZERO)) begin
            state_r <= IDLE;
          end
        end
        RD_BURST: begin
          if (cmd_fire_s) begin
            addr_r <= addr_r + STEP;
          end
          cmd_left_r <= cmd_left_nxt_s;
          if ((cmd_left_nxt_s == CNT_ZERO) && (outstanding_nxt_s == OUT_ZERO)) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_s;
  assign wr_ready     = wr_ready_s;
  assign app_en       = app_en_s;
  assign app_wdf_wren = wdf_wren_s;
  assign app_wdf_end  = wdf_wren_s;
  assign app_wdf_data = wr_data;
  assign app_wdf_mask = wr_mask;
  assign app_addr     = addr_r;
  assign app_cmd      = cmd_r;
  assign rd_data      = rd_data_r;
  assign rd_valid     = rd_valid_r;
  assign rd_last      = rd_last_r;
  assign busy         = (state_r != IDLE);
  assign err_unexp_rd = err_r;

endmodule

// File: tb/tb_ddr_app_master.sv
// Directed bench for ddr_app_master: reset, calibration gating, write/read bursts,
// stalls, address wrap, outstanding-read throttling and unexpected read data.
module tb_ddr_app_master;

  localparam int AW = 27;
  localparam int DW = 256;
  localparam int LW = 8;
  localparam int MW = DW / 8;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic [MW-1:0] wr_mask = '0;
  logic          wr_valid = 1'b0, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_last, busy, err_unexp_rd;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy = 1'b0;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_wren, app_wdf_end, app_wdf_rdy = 1'b0;
  logic [DW-1:0] app_rd_data = '0;
  logic          app_rd_data_valid = 1'b0;
  logic          init_calib_complete = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ddr_app_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .ADDR_STEP(8), .MAX_OUTSTANDING(2)
  ) dut (
    .clock(clock), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_mask(wr_mask), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .busy(busy), .err_unexp_rd(err_unexp_rd),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .init_calib_complete(init_calib_complete)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dpat(input int i, input logic [31:0] seed);
    return {8{seed + 32'(i)}};
  endfunction

  function automatic logic [MW-1:0] mpat(input int i);
    logic [7:0] b;
    b = 8'(8'h11 * (i + 1));
    return {4{b}};
  endfunction

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_req(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int t;
    t = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = l;
    #1;
    while (!req_ready && t < 20) begin
      step();
      #1;
      t++;
    end
    check("req_accept", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_write(input logic [AW-1:0] a, input int beats, input logic rnd,
                           input logic [31:0] seed);
    int c, d, t;
    logic stall;
    logic [AW-1:0] pa, ea;
    logic [2:0] pc;
    c = 0; d = 0; t = 0; stall = 1'b0; pa = '0; pc = 3'b000;
    while ((c < beats || d < beats) && t < 300) begin
      app_rdy     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      app_wdf_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_valid    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data     = dpat(d, seed);
      wr_mask     = mpat(d);
      #1;
      if (stall) begin
        check("wr_en_hold", app_en, 1'b1);
        check("wr_addr_hold", app_addr, pa);
        check("wr_cmd_hold", app_cmd, pc);
      end
      stall = app_en && !app_rdy;
      pa = app_addr;
      pc = app_cmd;
      if (app_en && app_rdy) begin
        ea = a + AW'(8 * c);
        check("wr_addr", app_addr, ea);
        check("wr_cmd", app_cmd, 3'b000);
        c++;
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        check("wr_ready", wr_ready, 1'b1);
        check("wdf_data", app_wdf_data, dpat(d, seed));
        check("wdf_mask", app_wdf_mask, mpat(d));
        check("wdf_end", app_wdf_end, 1'b1);
        d++;
      end
      step();
      t++;
    end
    check("wr_in_time", (t < 300), 1'b1);
    check("wr_busy_drop", busy, 1'b0);
    wr_valid = 1'b1;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("wr_no_extra", {app_en, app_wdf_wren}, 2'b00);
      step();
    end
    check("wr_cmd_count", c, beats);
    check("wr_data_count", d, beats);
    wr_valid = 1'b0;
  endtask

  initial begin : main
    logic [AW-1:0] exp_rd [3];
    int q [$];
    int c, ret, rv, t;
    logic drv;

    // Reset with random inputs.
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr = AW'($urandom());
      req_len = LW'($urandom());
      wr_valid = 1'($urandom_range(0, 1));
      app_rdy = 1'($urandom_range(0, 1));
      app_wdf_rdy = 1'($urandom_range(0, 1));
      app_rd_data = {8{$urandom()}};
      app_rd_data_valid = 1'($urandom_range(0, 1));
      init_calib_complete = 1'($urandom_range(0, 1));
      step();
    end
    check("rst_outs", {req_ready, wr_ready, rd_valid, rd_last, busy, err_unexp_rd,
                       app_en, app_wdf_wren, app_wdf_end}, 9'b0);
    check("rst_app_addr", app_addr, '0);
    check("rst_app_cmd", app_cmd, 3'b000);
    check("rst_rd_data", rd_data, '0);

    // Calibration gating.
    rst = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 27'h100; req_len = 8'd3;
    wr_valid = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data_valid = 1'b0; init_calib_complete = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("calib_req_ready", req_ready, 1'b0);
      check("calib_app_en", app_en, 1'b0);
      check("calib_busy", busy, 1'b0);
      step();
    end
    req_valid = 1'b0;
    init_calib_complete = 1'b1;
    step();

    // Write burst, no stalls.
    issue_req(1'b1, 27'h100, 8'd3);
    run_write(27'h100, 4, 1'b0, 32'hA000_0000);

    // Write burst, random stalls.
    issue_req(1'b1, 27'h100, 8'd3);
    run_write(27'h100, 4, 1'b1, 32'hB000_0000);

    // Read burst wrapping past the top of the address space, late returns.
    exp_rd[0] = 27'h7FFFFF8;
    exp_rd[1] = 27'h0000000;
    exp_rd[2] = 27'h0000008;
    app_rdy = 1'b1;
    issue_req(1'b0, 27'h7FFFFF8, 8'd2);
    c = 0; ret = 0; rv = 0; t = 0;
    while (rv < 3 && t < 200) begin
      drv = (q.size() > 0) && (q[0] <= t);
      app_rd_data_valid = drv;
      app_rd_data = dpat(ret, 32'hC000_0000);
      #1;
      if (c == 2 && ret == 0) begin
        check("rd_en_gated", app_en, 1'b0);
      end
      if (app_en && app_rdy) begin
        if (c < 3) begin
          check("rd_addr", app_addr, exp_rd[c]);
        end
        check("rd_cmd", app_cmd, 3'b001);
        q.push_back(t + 10);
        c++;
      end
      if (rd_valid) begin
        check("rd_data", rd_data, dpat(rv, 32'hC000_0000));
        check("rd_last", rd_last, (rv == 2));
        if (rv == 2) begin
          check("rd_busy_drop", busy, 1'b0);
        end
        rv++;
      end
      if (drv) begin
        void'(q.pop_front());
        ret++;
      end
      step();
      t++;
    end
    app_rd_data_valid = 1'b0;
    check("rd_in_time", (t < 200), 1'b1);
    check("rd_cmd_count", c, 3);
    check("rd_no_err", err_unexp_rd, 1'b0);

    // Unexpected read data while idle.
    app_rd_data = dpat(7, 32'hDEAD_0000);
    app_rd_data_valid = 1'b1;
    step();
    app_rd_data_valid = 1'b0;
    #1;
    check("unexp_rd_valid", rd_valid, 1'b1);
    check("unexp_rd_data", rd_data, dpat(7, 32'hDEAD_0000));
    check("unexp_err_set", err_unexp_rd, 1'b1);
    check("unexp_busy", busy, 1'b0);
    step();
    #1;
    check("unexp_single_pulse", rd_valid, 1'b0);
    repeat (3) step();
    check("unexp_err_sticky", err_unexp_rd, 1'b1);

    // Reset in the middle of a read with two reads outstanding.
    issue_req(1'b0, 27'h40, 8'd3);
    repeat (6) step();
    check("mid_rd_throttled", app_en, 1'b0);
    check("mid_rd_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_err", err_unexp_rd, 1'b0);
    check("post_rst_app_en", app_en, 1'b0);
    check("post_rst_req_ready", req_ready, 1'b1);
    issue_req(1'b1, 27'h200, 8'd1);
    run_write(27'h200, 2, 1'b0, 32'hE000_0000);
    app_rd_data = dpat(0, 32'hF000_0000);
    app_rd_data_valid = 1'b1;
    step();
    app_rd_data_valid = 1'b0;
    #1;
    check("late_rd_valid", rd_valid, 1'b1);
    check("late_rd_err", err_unexp_rd, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
